cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 9-bit CPU. It fetches each instruction over an instruction-memory handshake, holds it in an instruction register, and drives the existing `Control` decoder. It then steps the datapath through decode, execute, memory and write-back phases, holding on data-memory wait states. It owns the PC and the retired-instruction counter, and signals completion on HALT.

---
 rtl/cpu_sequencer_pkg.sv | 44 ++++
 rtl/cpu_sequencer_control.sv | 38 +++
 rtl/cpu_sequencer.sv | 157 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : Defs
// Description : Shared definitions for the 9-bit CPU sequencer: FSM state
//               enum, opcode encodings, HALT encoding and the control bundle
//               produced by the Control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package Defs;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    // Instruction format: [8:6] opcode, [5:3] rs, [2:0] rt
    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_LW     = 3'b101;
    localparam logic [2:0] OP_SW     = 3'b110;
    localparam logic [2:0] OP_BRANCH = 3'b111;

    localparam logic [8:0] HALT_INSTR = 9'b111_111_111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       halt;
    } ControlSignals;

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_control.sv
`default_nettype none
// ============================================================================
// Module      : Control
// Description : Combinational instruction decoder for the 9-bit CPU.
//               init  in  1  - forces all controls to zero while high
//               ir    in  9  - instruction register
//               ctrl  out    - decoded ControlSignals bundle
// Revision    : 1.0 - initial release
// ============================================================================
module Control
    import Defs::*;
(
    input  logic          init,
    input  logic [8:0]    ir,
    output ControlSignals ctrl
);

    always_comb begin
        ctrl = '0;
        if (!init) begin
            ctrl.alu_op = ir[8:6];
            ctrl.halt   = (ir == HALT_INSTR);
            case (ir[8:6])
                OP_LW: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                OP_SW:     ctrl.mem_write = 1'b1;
                // HALT shares the branch opcode but is not a branch
                OP_BRANCH: ctrl.branch    = (ir != HALT_INSTR);
                default:   ctrl.reg_write = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 9-bit
//               CPU. Owns PC, instruction register and retired-instruction
//               counter; signals completion on HALT.
//               Optional macro SEQ_TIMEOUT_EN adds a data-memory wait timeout
//               that sets sticky err and aborts to DONE.
// Ports       : clk, rst_n (async active-low), start,
//               imem_req/imem_valid/imem_instr (instruction fetch),
//               pc, ir, ctrl (decoded controls),
//               rf_we, mem_rd, mem_wr, dmem_ready (datapath strobes),
//               branch_taken, branch_target (sampled in EXEC),
//               instr_cnt, busy, done, err (status)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import Defs::*;
#(
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_valid,
    input  logic [8:0]       imem_instr,
    output logic [PC_W-1:0]  pc,
    output logic [8:0]       ir,
    output ControlSignals    ctrl,
    output logic             rf_we,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    seq_state_t state;
    seq_state_t state_nxt;
    logic [2:0] op;
    logic       launch;
    logic       retire;
    logic       timeout_hit;
    logic       ctrl_init;

    assign op        = ir[8:6];
    assign ctrl_init = !rst_n;
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign retire    = ((state == S_EXEC) && (op == OP_BRANCH) && (ir != HALT_INSTR))
                     || ((state == S_MEM) && dmem_ready && (op == OP_SW))
                     || (state == S_WB);

    Control u_control (
        .init (ctrl_init),
        .ir   (ir),
        .ctrl (ctrl)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
            S_FETCH:        if (imem_valid) state_nxt = S_DECODE;
            S_DECODE:       state_nxt = (ir == HALT_INSTR) ? S_DONE : S_EXEC;
            S_EXEC: begin
                if ((op == OP_LW) || (op == OP_SW)) state_nxt = S_MEM;
                else if (op == OP_BRANCH)           state_nxt = S_FETCH;
                else                                state_nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)       state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
                else if (timeout_hit) state_nxt = S_DONE;
            end
            S_WB:           state_nxt = S_FETCH;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one is aligned
    // exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            instr_cnt <= '0;
            imem_req  <= 1'b0;
            rf_we     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == S_FETCH);
            rf_we    <= (state_nxt == S_WB);
            mem_rd   <= (state_nxt == S_MEM) && (op == OP_LW);
            mem_wr   <= (state_nxt == S_MEM) && (op == OP_SW);
            busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done     <= (state_nxt == S_DONE);

            if ((state == S_FETCH) && imem_valid) begin
                ir <= imem_instr;
            end

            if (launch) begin
                pc        <= '0;
                instr_cnt <= '0;
            end else if (retire) begin
                if ((state == S_EXEC) && branch_taken) pc <= branch_target;
                else                                   pc <= pc + PC_W'(1);
                if (!(&instr_cnt)) instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TMR_W-1:0] wait_cnt;
    logic             err_q;

    // wait_cnt holds the number of MEM cycles already spent without ready,
    // so the abort fires in the TIMEOUT-th consecutive waiting cycle.
    assign timeout_hit = (state == S_MEM) && !dmem_ready
                       && (wait_cnt == TMR_W'(TIMEOUT - 1));
    assign err         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != S_MEM)  wait_cnt <= '0;
            else if (!dmem_ready) wait_cnt <= wait_cnt + TMR_W'(1);

            if (launch)           err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    logic [TMR_W-1:0] unused_timeout;

    assign unused_timeout = TMR_W'(TIMEOUT);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer. Two instances (8-bit
//               and 4-bit PC/counter) run in lockstep on shared stimulus and
//               are compared against an instruction-level reference model.
//               Optional macro SEQ_TIMEOUT_EN enables the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
    import Defs::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_valid = 1'b0;
    logic [8:0]    imem_instr = '0;
    logic          dmem_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic [7:0]    branch_target = '0;

    logic          imem_req, rf_we, mem_rd, mem_wr, busy, done, err;
    logic [7:0]    pc;
    logic [8:0]    ir;
    logic [15:0]   instr_cnt;
    ControlSignals ctrl;

    logic          s_imem_req, s_rf_we, s_mem_rd, s_mem_wr, s_busy, s_done, s_err;
    logic [3:0]    s_pc;
    logic [8:0]    s_ir;
    logic [3:0]    s_instr_cnt;
    ControlSignals s_ctrl;

    cpu_sequencer #(.PC_W(8), .CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_valid(imem_valid), .imem_instr(imem_instr),
        .pc(pc), .ir(ir), .ctrl(ctrl), .rf_we(rf_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_cnt(instr_cnt), .busy(busy), .done(done), .err(err)
    );

    cpu_sequencer #(.PC_W(4), .CNT_W(4), .TIMEOUT(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(s_imem_req), .imem_valid(imem_valid), .imem_instr(imem_instr),
        .pc(s_pc), .ir(s_ir), .ctrl(s_ctrl), .rf_we(s_rf_we),
        .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .branch_target(branch_target[3:0]),
        .instr_cnt(s_instr_cnt), .busy(s_busy), .done(s_done), .err(s_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mpc    = 0;   // architectural PC of the model (unbounded, reduced per instance)
    int mcnt   = 0;   // retired instructions of the model (saturated per instance)
    bit merr   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit e_req, input bit e_rd, input bit e_wr,
                                 input bit e_we, input bit e_busy, input bit e_done);
        check({tag, "_strobes"}, {26'd0, imem_req, mem_rd, mem_wr, rf_we, busy, done},
              {26'd0, e_req, e_rd, e_wr, e_we, e_busy, e_done});
        check({tag, "_strobes_s"}, {26'd0, s_imem_req, s_mem_rd, s_mem_wr, s_rf_we, s_busy, s_done},
              {26'd0, e_req, e_rd, e_wr, e_we, e_busy, e_done});
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"},    32'(pc),          32'(mpc % 256));
        check({tag, "_pc_s"},  32'(s_pc),        32'(mpc % 16));
        check({tag, "_cnt"},   32'(instr_cnt),   32'((mcnt > 65535) ? 65535 : mcnt));
        check({tag, "_cnt_s"}, 32'(s_instr_cnt), 32'((mcnt > 15) ? 15 : mcnt));
        check({tag, "_err"},   {30'd0, err, s_err}, {30'd0, merr, merr});
    endtask

    // Irrelevant inputs get random values: the DUT must ignore them.
    task automatic drive_noise();
        start         = 1'($urandom);
        imem_valid    = 1'($urandom);
        imem_instr    = 9'($urandom);
        dmem_ready    = 1'($urandom);
        branch_taken  = 1'($urandom);
        branch_target = 8'($urandom);
    endtask

    task automatic do_start();
        start      = 1'b1;
        imem_valid = 1'b0;
        @(negedge clk);
        mpc  = 0;
        mcnt = 0;
        merr = 1'b0;
    endtask

    // Entered at the negedge of the first FETCH cycle; leaves at the negedge
    // of the next instruction's first FETCH cycle.
    task automatic run_instr(input logic [8:0] instr, input int fi, input int mw,
                             input bit bt, input logic [7:0] tgt);
        logic [2:0] op;
        bit is_lw, is_sw, is_br;
        int mem_s, mem_e, wb, len;
        op    = instr[8:6];
        is_lw = (op == OP_LW);
        is_sw = (op == OP_SW);
        is_br = (op == OP_BRANCH);
        mem_s = fi + 3;
        mem_e = fi + 3 + mw;
        wb    = is_lw ? mem_e + 1 : ((is_sw || is_br) ? -1 : fi + 3);
        len   = is_br ? fi + 3 : is_sw ? fi + 4 + mw : is_lw ? fi + 5 + mw : fi + 4;
        check_arch("fetch");
        for (int k = 0; k < len; k++) begin
            check_outputs("cyc", k <= fi, is_lw && k >= mem_s && k <= mem_e,
                          is_sw && k >= mem_s && k <= mem_e, k == wb, 1'b1, 1'b0);
            if (k == fi + 2) begin
                check("ir", 32'(ir), 32'(instr));
                check("ir_s", 32'(s_ir), 32'(instr));
                check("ctrl", {29'd0, ctrl.reg_write, ctrl.mem_read, ctrl.mem_write},
                      {29'd0, !(is_sw || is_br), is_lw, is_sw});
                check("ctrl_s", {29'd0, s_ctrl.reg_write, s_ctrl.mem_read, s_ctrl.mem_write},
                      {29'd0, !(is_sw || is_br), is_lw, is_sw});
            end
            drive_noise();
            if (k < fi) imem_valid = 1'b0;
            if (k == fi) begin
                imem_valid = 1'b1;
                imem_instr = instr;
            end
            if (k >= mem_s && k <= mem_e) dmem_ready = (k == mem_e);
            if (k == fi + 2) begin
                branch_taken  = bt;
                branch_target = tgt;
            end
            @(negedge clk);
        end
        mcnt++;
        mpc = (is_br && bt) ? 32'(tgt) : (mpc + 1) % 256;
    endtask

    task automatic run_halt(input int fi);
        check_arch("halt_fetch");
        for (int k = 0; k < fi + 2; k++) begin
            check_outputs("halt_cyc", k <= fi, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            drive_noise();
            if (k < fi) imem_valid = 1'b0;
            if (k == fi) begin
                imem_valid = 1'b1;
                imem_instr = HALT_INSTR;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_outputs("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_arch("done");
        check("done_ir", 32'(ir), 32'(HALT_INSTR));
        check("done_halt", {31'd0, ctrl.halt}, 32'd1);
        @(negedge clk);
        check_outputs("done_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_arch("done_hold");
    endtask

    initial begin
        logic [8:0] ins;
        // Reset state
        #2;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_arch("reset");
        check("reset_ir", 32'(ir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADD then HALT
        do_start();
        run_instr(9'b100_001_010, 0, 0, 1'b0, 8'h00);
        run_halt(0);

        // LW with three wait cycles, branches taken / not taken
        do_start();
        run_instr(9'b101_000_000, 0, 3, 1'b0, 8'h00);
        run_instr(9'b111_000_001, 1, 0, 1'b1, 8'h20);
        run_instr(9'b111_010_001, 0, 0, 1'b0, 8'h00);
        run_instr(9'b110_001_001, 2, 0, 1'b0, 8'h00);
        // Wrap of the 8-bit PC across 255
        run_instr(9'b111_000_000, 0, 0, 1'b1, 8'hFE);
        for (int i = 0; i < 3; i++) run_instr(9'b000_011_101, 0, 0, 1'b0, 8'h00);

        // Random program; the 4-bit instance wraps and saturates
        for (int i = 0; i < 300; i++) begin
            ins = 9'($urandom);
            if (ins == HALT_INSTR) ins = 9'b111_111_110;
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), 8'($urandom));
        end

        // Reset in the middle of an SW memory access
        start      = 1'b0;
        imem_valid = 1'b1;
        imem_instr = 9'b110_000_000;
        dmem_ready = 1'b0;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs("sw_mem", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        mpc  = 0;
        mcnt = 0;
        merr = 1'b0;
        check_outputs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_arch("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_start();
        run_instr(9'b100_000_001, 0, 0, 1'b0, 8'h00);
`ifdef SEQ_TIMEOUT_EN
        // SW whose data memory never answers: abort after TIMEOUT MEM cycles
        imem_valid = 1'b1;
        imem_instr = 9'b110_010_011;
        dmem_ready = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_outputs("to_mem", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        merr = 1'b1;
        check_outputs("to_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_arch("to_done");
        do_start();
        check_arch("to_restart");
        run_instr(9'b001_000_001, 0, 0, 1'b0, 8'h00);
`endif
        run_halt(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
